// File: rtl/hazard_pkg.sv
// Shared definitions for the IF/ID -> ID/EX hazard controller.
// Contents: MIPS opcode constants, instruction field widths, FSM state enum
// and a packed view of the instruction fields the hazard logic inspects.
package hazard_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned WIN_W   = 3;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } state_e;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [15:0]      low;
   } instr_fields_t;

   // Opcodes whose rt field is a source operand (not a destination).
   function automatic logic op_uses_rt(input logic [OP_W-1:0] op);
      return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/hazard_match.sv
// Load-use hazard detector (combinational).
// Ports:
//   instr          in  32  instruction in IF/ID
//   id_ex_mem_read in  1   load currently in EX
//   id_ex_rt       in  5   load destination register
//   hz             out 1   consumer in ID reads the load destination
module hazard_match
   import hazard_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
   input  logic               id_ex_mem_read,
   input  logic [REG_W-1:0]   id_ex_rt,
   output logic               hz
);

   instr_fields_t f;
   logic          unused_low;

   assign f          = instr_fields_t'(instr);
   assign unused_low = ^f.low;

   // $zero is never a real dependency, so rt==0 loads never stall.
   always_comb begin
      hz = id_ex_mem_read && (id_ex_rt != '0) &&
           ((id_ex_rt == f.rs) || (op_uses_rt(f.op) && (id_ex_rt == f.rt)));
   end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Hazard controller for the IF/ID -> ID/EX boundary of the 5-stage MIPS core.
// Load-use hazards hold PC/IF-ID and bubble ID/EX; taken branches flush IF/ID
// and bubble ID/EX. Multi-cycle windows are sequenced by a RUN/STALL/FLUSH FSM
// with a 3-bit down-counter. Outputs are Mealy (same-cycle response).
// Optional feature macro: HAZARD_STATS_EN adds saturating stall/flush counters.
// Ports:
//   clk, rst (sync, active-high)
//   if_id_instr, id_ex_mem_read, id_ex_rt, ex_mem_br_taken  (inputs)
//   pc_write, if_id_write, if_id_flush, id_ex_bubble, busy   (outputs)
//   stall_count, flush_count  (HAZARD_STATS_EN only)
module id_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned LOAD_STALL_CYC = 1,
   parameter int unsigned BR_FLUSH_CYC   = 1,
   parameter int unsigned CNT_W          = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] if_id_instr,
   input  logic               id_ex_mem_read,
   input  logic [REG_W-1:0]   id_ex_rt,
   input  logic               ex_mem_br_taken,
   output logic               pc_write,
   output logic               if_id_write,
   output logic               if_id_flush,
   output logic               id_ex_bubble,
   output logic               busy
`ifdef HAZARD_STATS_EN
   ,
   output logic [CNT_W-1:0]   stall_count,
   output logic [CNT_W-1:0]   flush_count
`endif
);

   localparam logic [WIN_W-1:0] STALL_RELOAD = WIN_W'(LOAD_STALL_CYC - 1);
   localparam logic [WIN_W-1:0] FLUSH_RELOAD = WIN_W'(BR_FLUSH_CYC - 1);
   localparam int unsigned      unused_cnt_w = CNT_W;

   state_e           state_q, state_d;
   logic [WIN_W-1:0] cnt_q, cnt_d;
   logic             hz;
   logic             stall_act;
   logic             flush_act;

   hazard_match u_match (
      .instr          (if_id_instr),
      .id_ex_mem_read (id_ex_mem_read),
      .id_ex_rt       (id_ex_rt),
      .hz             (hz)
   );

   // State and window counter.
   always_ff @(posedge clk) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
   end

   // Next state and Mealy output decode.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      stall_act    = 1'b0;
      flush_act    = 1'b0;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      busy         = 1'b0;

      if (rst) begin
         state_d = RUN;
         cnt_d   = '0;
      end else begin
         busy = (state_q != RUN);
         unique case (state_q)
            RUN, STALL: begin
               // A taken branch wins over any stall: the stalled instr is wrong-path.
               if (ex_mem_br_taken) begin
                  flush_act = 1'b1;
                  if (BR_FLUSH_CYC > 1) begin
                     state_d = FLUSH;
                     cnt_d   = FLUSH_RELOAD;
                  end else begin
                     state_d = RUN;
                     cnt_d   = '0;
                  end
               end else if (state_q == STALL) begin
                  stall_act = 1'b1;
                  cnt_d     = cnt_q - WIN_W'(1);
                  if (cnt_q == WIN_W'(1)) state_d = RUN;
               end else if (hz) begin
                  stall_act = 1'b1;
                  if (LOAD_STALL_CYC > 1) begin
                     state_d = STALL;
                     cnt_d   = STALL_RELOAD;
                  end
               end
            end
            FLUSH: begin
               flush_act = 1'b1;
               if (ex_mem_br_taken) begin
                  cnt_d = FLUSH_RELOAD;
               end else begin
                  cnt_d = cnt_q - WIN_W'(1);
                  if (cnt_q == WIN_W'(1)) state_d = RUN;
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase
      end

      if (flush_act) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (stall_act) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

`ifdef HAZARD_STATS_EN
   // Saturating per-cycle stall/flush statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall_act && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
         if (flush_act && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl. Three instances share the stimulus:
//   u0 defaults, u1 LOAD_STALL_CYC=3, u2 LOAD_STALL_CYC=3/BR_FLUSH_CYC=4/CNT_W=2.
// Output vector per instance: {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy}.
module tb_id_hazard_ctrl;

   localparam logic [4:0] NORM  = 5'b11000;
   localparam logic [4:0] STL_R = 5'b00010;
   localparam logic [4:0] STL_B = 5'b00011;
   localparam logic [4:0] FLS_R = 5'b11110;
   localparam logic [4:0] FLS_B = 5'b11111;

   localparam logic [5:0] RT  = 6'h00;
   localparam logic [5:0] BEQ = 6'h04;
   localparam logic [5:0] BNE = 6'h05;
   localparam logic [5:0] SW  = 6'h2B;
   localparam logic [5:0] LW  = 6'h23;
   localparam logic [5:0] ADI = 6'h08;

   typedef struct {
      logic        rst;
      logic [31:0] instr;
      logic        mr;
      logic [4:0]  rt;
      logic        br;
      logic [4:0]  exp;
   } row_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = '0;
   logic        mr = 1'b0;
   logic [4:0]  ld_rt = '0;
   logic        br = 1'b0;
   logic [4:0]  o0, o1, o2;
   logic [4:0]  sb[$];
   int          passed = 0;
   int          total = 0;

`ifdef HAZARD_STATS_EN
   logic [31:0] sc0, fc0, sc1, fc1;
   logic [1:0]  sc2, fc2;
`endif

   always #5 clk = ~clk;

   id_hazard_ctrl u0 (
      .clk(clk), .rst(rst), .if_id_instr(instr), .id_ex_mem_read(mr), .id_ex_rt(ld_rt),
      .ex_mem_br_taken(br), .pc_write(o0[4]), .if_id_write(o0[3]), .if_id_flush(o0[2]),
      .id_ex_bubble(o0[1]), .busy(o0[0])
`ifdef HAZARD_STATS_EN
      , .stall_count(sc0), .flush_count(fc0)
`endif
   );

   id_hazard_ctrl #(.LOAD_STALL_CYC(3)) u1 (
      .clk(clk), .rst(rst), .if_id_instr(instr), .id_ex_mem_read(mr), .id_ex_rt(ld_rt),
      .ex_mem_br_taken(br), .pc_write(o1[4]), .if_id_write(o1[3]), .if_id_flush(o1[2]),
      .id_ex_bubble(o1[1]), .busy(o1[0])
`ifdef HAZARD_STATS_EN
      , .stall_count(sc1), .flush_count(fc1)
`endif
   );

   id_hazard_ctrl #(.LOAD_STALL_CYC(3), .BR_FLUSH_CYC(4), .CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .if_id_instr(instr), .id_ex_mem_read(mr), .id_ex_rt(ld_rt),
      .ex_mem_br_taken(br), .pc_write(o2[4]), .if_id_write(o2[3]), .if_id_flush(o2[2]),
      .id_ex_bubble(o2[1]), .busy(o2[0])
`ifdef HAZARD_STATS_EN
      , .stall_count(sc2), .flush_count(fc2)
`endif
   );

   function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt);
      return {op, rs, rt, 16'h3020};
   endfunction

   function automatic row_t mk(input logic r, input logic [31:0] i, input logic m,
                               input logic [4:0] t, input logic b, input logic [4:0] e);
      row_t x;
      x.rst = r; x.instr = i; x.mr = m; x.rt = t; x.br = b; x.exp = e;
      return x;
   endfunction

   function automatic logic [4:0] pick(input int s);
      case (s)
         0:       return o0;
         1:       return o1;
         default: return o2;
      endcase
   endfunction

   // Drive one row just after the active edge and queue its expected outputs.
   task automatic drive(input row_t r);
      @(posedge clk);
      #1;
      rst = r.rst; instr = r.instr; mr = r.mr; ld_rt = r.rt; br = r.br;
      sb.push_back(r.exp);
   endtask

   task automatic test_reset();
      row_t rows[$];
      logic [4:0] e;
      rows.push_back(mk(1, '0, 0, 0, 0, NORM));
      rows.push_back(mk(1, ins(RT, 5'd5, 5'd2), 1, 5'd5, 0, NORM));
      rows.push_back(mk(0, '0, 0, 0, 0, NORM));
      foreach (rows[i]) begin
         drive(rows[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (o0 !== e) $display("FAIL reset row%0d: got %b expected %b", i, o0, e);
         else passed++;
      end
   endtask

   task automatic test_load_use();
      row_t rows[$];
      logic [4:0] e;
      rows.push_back(mk(1, '0, 0, 0, 0, NORM));
      rows.push_back(mk(0, '0, 0, 0, 0, NORM));
      rows.push_back(mk(0, ins(RT, 5'd5, 5'd2), 1, 5'd5, 0, STL_R));
      rows.push_back(mk(0, ins(RT, 5'd5, 5'd2), 0, 5'd5, 0, NORM));
      foreach (rows[i]) begin
         drive(rows[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (o0 !== e) $display("FAIL load_use row%0d: got %b expected %b", i, o0, e);
         else passed++;
      end
   endtask

   task automatic test_match_cases();
      row_t rows[$];
      logic [4:0] e;
      rows.push_back(mk(1, '0, 0, 0, 0, NORM));
      rows.push_back(mk(0, ins(RT, 5'd0, 5'd0), 1, 5'd0, 0, NORM));
      rows.push_back(mk(0, ins(RT, 5'd5, 5'd5), 0, 5'd5, 0, NORM));
      rows.push_back(mk(0, ins(ADI, 5'd1, 5'd6), 1, 5'd6, 0, NORM));
      rows.push_back(mk(0, ins(SW, 5'd1, 5'd6), 1, 5'd6, 0, STL_R));
      rows.push_back(mk(0, ins(BEQ, 5'd1, 5'd6), 1, 5'd6, 0, STL_R));
      rows.push_back(mk(0, ins(BNE, 5'd1, 5'd6), 1, 5'd6, 0, STL_R));
      rows.push_back(mk(0, ins(RT, 5'd1, 5'd6), 1, 5'd6, 0, STL_R));
      rows.push_back(mk(0, ins(LW, 5'd6, 5'd1), 1, 5'd6, 0, STL_R));
      rows.push_back(mk(0, ins(LW, 5'd1, 5'd6), 1, 5'd6, 0, NORM));
      rows.push_back(mk(0, ins(RT, 5'd7, 5'd8), 1, 5'd6, 0, NORM));
      foreach (rows[i]) begin
         drive(rows[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (o0 !== e) $display("FAIL match row%0d: got %b expected %b", i, o0, e);
         else passed++;
      end
   endtask

   task automatic test_multi_stall();
      row_t rows[$];
      logic [4:0] e;
      rows.push_back(mk(1, '0, 0, 0, 0, NORM));
      rows.push_back(mk(0, ins(RT, 5'd5, 5'd2), 1, 5'd5, 0, STL_R));
      rows.push_back(mk(0, ins(RT, 5'd5, 5'd2), 0, 5'd0, 0, STL_B));
      rows.push_back(mk(0, ins(RT, 5'd5, 5'd2), 0, 5'd0, 0, STL_B));
      rows.push_back(mk(0, ins(RT, 5'd5, 5'd2), 0, 5'd0, 0, NORM));
      rows.push_back(mk(0, '0, 0, 0, 0, NORM));
      foreach (rows[i]) begin
         drive(rows[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (o1 !== e) $display("FAIL multi_stall row%0d: got %b expected %b", i, o1, e);
         else passed++;
      end
   endtask

   task automatic test_branch_vs_hazard();
      row_t rows[$];
      logic [4:0] e;
      rows.push_back(mk(1, '0, 0, 0, 0, NORM));
      rows.push_back(mk(0, ins(RT, 5'd5, 5'd2), 1, 5'd5, 1, FLS_R));
      rows.push_back(mk(0, '0, 0, 0, 0, NORM));
      rows.push_back(mk(0, '0, 0, 0, 0, NORM));
      foreach (rows[i]) begin
         drive(rows[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (o1 !== e) $display("FAIL br_vs_hz row%0d: got %b expected %b", i, o1, e);
         else passed++;
      end
   endtask

   task automatic test_branch_in_stall();
      row_t rows[$];
      logic [4:0] e;
      rows.push_back(mk(1, '0, 0, 0, 0, NORM));
      rows.push_back(mk(0, ins(RT, 5'd5, 5'd2), 1, 5'd5, 0, STL_R));
      rows.push_back(mk(0, ins(RT, 5'd5, 5'd2), 0, 5'd0, 1, FLS_B));
      rows.push_back(mk(0, '0, 0, 0, 0, NORM));
      rows.push_back(mk(0, '0, 0, 0, 0, NORM));
      foreach (rows[i]) begin
         drive(rows[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (o1 !== e) $display("FAIL br_in_stall row%0d: got %b expected %b", i, o1, e);
         else passed++;
      end
   endtask

   task automatic test_flush_window();
      row_t rows[$];
      logic [4:0] e;
      rows.push_back(mk(1, '0, 0, 0, 0, NORM));
      rows.push_back(mk(0, '0, 0, 0, 1, FLS_R));
      rows.push_back(mk(0, '0, 0, 0, 0, FLS_B));
      rows.push_back(mk(0, '0, 0, 0, 1, FLS_B));
      rows.push_back(mk(0, '0, 0, 0, 0, FLS_B));
      rows.push_back(mk(0, '0, 0, 0, 0, FLS_B));
      rows.push_back(mk(0, '0, 0, 0, 0, FLS_B));
      rows.push_back(mk(0, '0, 0, 0, 0, NORM));
      rows.push_back(mk(0, '0, 0, 0, 1, FLS_R));
      rows.push_back(mk(0, '0, 0, 0, 0, FLS_B));
      rows.push_back(mk(1, '0, 0, 0, 0, NORM));
      rows.push_back(mk(0, '0, 0, 0, 0, NORM));
      rows.push_back(mk(0, '0, 0, 0, 0, NORM));
      foreach (rows[i]) begin
         drive(rows[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (o2 !== e) $display("FAIL flush_window row%0d: got %b expected %b", i, o2, e);
         else passed++;
      end
   endtask

`ifdef HAZARD_STATS_EN
   task automatic test_stats();
      row_t rows[$];
      logic [4:0] e;
      rows.push_back(mk(1, '0, 0, 0, 0, NORM));
      rows.push_back(mk(0, ins(RT, 5'd5, 5'd2), 1, 5'd5, 0, STL_R));
      rows.push_back(mk(0, '0, 0, 0, 0, NORM));
      rows.push_back(mk(0, ins(SW, 5'd1, 5'd9), 1, 5'd9, 0, STL_R));
      rows.push_back(mk(0, '0, 0, 0, 0, NORM));
      rows.push_back(mk(0, '0, 0, 0, 1, FLS_R));
      rows.push_back(mk(0, '0, 0, 0, 0, NORM));
      foreach (rows[i]) begin
         drive(rows[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (o0 !== e) $display("FAIL stats row%0d: got %b expected %b", i, o0, e);
         else passed++;
      end
      total++;
      if (sc0 !== 32'd2) $display("FAIL stall_count: got %0d expected 2", sc0);
      else passed++;
      total++;
      if (fc0 !== 32'd1) $display("FAIL flush_count: got %0d expected 1", fc0);
      else passed++;

      rows.delete();
      rows.push_back(mk(1, '0, 0, 0, 0, NORM));
      rows.push_back(mk(0, '0, 0, 0, 1, FLS_R));
      rows.push_back(mk(0, '0, 0, 0, 0, FLS_B));
      rows.push_back(mk(0, '0, 0, 0, 0, FLS_B));
      rows.push_back(mk(0, '0, 0, 0, 0, FLS_B));
      rows.push_back(mk(0, '0, 0, 0, 0, NORM));
      foreach (rows[i]) begin
         drive(rows[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (o2 !== e) $display("FAIL stats_sat row%0d: got %b expected %b", i, o2, e);
         else passed++;
      end
      total++;
      if (fc2 !== 2'd3) $display("FAIL flush_count_sat: got %0d expected 3", fc2);
      else passed++;
      total++;
      if (sc2 !== 2'd0) $display("FAIL stall_count_sat: got %0d expected 0", sc2);
      else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_load_use();
      test_match_cases();
      test_multi_stall();
      test_branch_vs_hazard();
      test_branch_in_stall();
      test_flush_window();
`ifdef HAZARD_STATS_EN
      test_stats();
`endif
      total++;
      if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
